muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Consumes the ID_EX register operands for MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a stall request back to the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  multiplicand / dividend (ID_EX readReg1).
- rt_val  in  WIDTH  multiplier / divisor (ID_EX readReg2).
- mthi  in  1  write rs_val into HI.
- mtlo  in  1  write rs_val into LO.
- hilo_read  in  1  MFHI/MFLO in EX this cycle.
- hi  out  WIDTH  HI register, registered.
- lo  out  WIDTH  LO register, registered.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO take a result.
- stall  out  1  freeze IF/ID/EX; combinational.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, all internal accumulators=0.
  - Reset mid-operation aborts it with no HI/LO update.
- States:
  - IDLE: start=1 at edge E0 → CALC. Latch |rs|, |rt| (signed ops) or raw values (unsigned). Latch the result-sign flags. counter=0.
  - CALC: one iteration per edge. MULT uses shift-add over a 2*WIDTH product. DIV uses restoring shift-subtract. After WIDTH iterations (edge E32) → FIX.
  - FIX: at edge E33, apply sign correction and write HI/LO. done=1 for the following cycle. → IDLE.
- Timing:
  - busy=1 from after E0 through the cycle before done.
  - Latency from the start edge to HI/LO valid is 33 edges. Next start is accepted at E34 at the earliest.
- Multiply result: {hi,lo} = full 2*WIDTH product. Signed product negated if sign(rs)≠sign(rt).
- Divide result: lo=quotient, hi=remainder.
  - Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0, with no trap.
- Divide by zero (rt_val=0): runs full latency, then lo=0xFFFFFFFF, hi=rs_val (raw). Same for signed and unsigned.
- mthi/mtlo in IDLE, no start: write at the next edge. Both may assert together.
- start and mthi/mtlo together in IDLE: start wins; the MT write is dropped.
- stall = busy & (start | hilo_read | mthi | mtlo).
  - start during busy is ignored; the in-flight op continues.
  - mt writes during busy are ignored.
  - The pipeline holds the instruction until stall drops, then reissues it.
- hilo_read in the done cycle: no stall. hi/lo already hold the new result.
- Operands are latched at E0; later changes on rs_val/rt_val have no effect.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - state enum IDLE/CALC/FIX.
  - constant DIV0_LO=32'hFFFFFFFF.
- Sub-module muldiv_step: combinational single iteration. It takes the accumulator, operand and op class, and returns the next accumulator. This covers the shift-add for multiply and the trial-subtract/restore for divide.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high 33 cycles.
- MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=0x00000064 at normal latency.
- Busy interactions:
  - start=1 with new operands at cycle 5 of a MULTU → stall=1, result unchanged from the first op.
  - hilo_read during busy → stall=1.
  - mthi 0x1234 during busy → ignored.
  - mthi 0x1234 in IDLE → hi=0x1234 next edge.
- rst_n low at CALC cycle 10 → immediately busy=0, stall=0, hi=lo=0, state IDLE. A new start after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: opcodes,
// controller states and the divide-by-zero quotient value.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, both over a 2*WIDTH accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_sum  = '0;
    rem_sh   = '0;
    trial    = '0;
    rem_next = '0;
    q_bit    = 1'b0;
    acc_next = acc;
    if (is_div) begin
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial  = rem_sh - {1'b0, opnd};
      if (trial[WIDTH]) begin
        rem_next = rem_sh[WIDTH-1:0];
        q_bit    = 1'b0;
      end else begin
        rem_next = trial[WIDTH-1:0];
        q_bit    = 1'b1;
      end
      acc_next = {rem_next, acc[WIDTH-2:0], q_bit};
    end else begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls the
// pipeline while an operation is in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_q, neg_r, div0;

  op_e                op_in;
  logic               in_signed, in_div, rs_neg, rt_neg, last_iter;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign rs_neg    = in_signed & rs_val[WIDTH-1];
  assign rt_neg    = in_signed & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_read | mthi | mtlo);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (is_div),
    .acc_next (acc_step)
  );

  // With a zero divisor the remainder ends up as |dividend|, so the normal
  // remainder sign fix already restores the raw dividend for HI.
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the accumulators are plain flops, so they reset with everything else;
  // a reset mid-operation therefore leaves no partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= in_div;
            div0   <= in_div & (rt_val == '0);
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= rs_neg;
            if (in_div) begin
              acc  <= {{WIDTH{1'b0}}, rs_mag};
              opnd <= rt_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, rt_mag};
              opnd <= rs_mag;
            end
          end else begin
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            lo <= div0 ? WIDTH'(DIV0_LO) : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
